// File: rtl/sseg_scan_ctrl_if.sv
// Bundle of the board-side signals of the seven-segment scan controller.
// The board logic uses the master view; the scan controller uses the slave view.
interface sseg_scan_ctrl_if;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       commit;
    logic       commit_done;
    logic [3:0] digit_en;
    logic [2:0] brightness;
    logic [3:0] value;
    logic [3:0] an;
    logic       frame_start;

    modport master (
        output wr_valid, wr_addr, wr_data, commit, digit_en, brightness,
        input  wr_ready, commit_done, value, an, frame_start
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit, digit_en, brightness,
        output wr_ready, commit_done, value, an, frame_start
    );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// A shadow bank is written by the board logic; it is copied to the active
// bank only at a frame boundary, so a frame never mixes old and new digits.
module sseg_scan_ctrl #(
    parameter int PRESCALE_W = 18
) (
    input  logic            mclk,
    input  logic            reset_n,
    sseg_scan_ctrl_if.slave bus
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [PRESCALE_W-1:0] prescale_q;
    logic [1:0]            idx_q;
    logic [3:0]            shadow_q [4];
    logic [3:0]            active_q [4];
    state_t                state_q;
    state_t                state_d;
    logic                  copy_d;
    logic                  wr_en;
    logic                  wrap;
    logic                  frame_edge;
    logic                  lit;
    logic [3:0]            an_d;
    logic [3:0]            value_q;
    logic [3:0]            an_q;
    logic                  commit_done_q;
    logic                  frame_edge_q;
    logic                  frame_start_q;

    assign wrap       = &prescale_q;
    assign frame_edge = wrap && (idx_q == 2'd3);
    // Writes are refused while a copy is outstanding so the committed image is stable.
    assign wr_en      = bus.wr_valid && (state_q == ST_IDLE);

    // Prescaler and digit index: the index advances once per dwell period.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
            idx_q      <= 2'd0;
        end else begin
            prescale_q <= prescale_q + 1'b1;
            if (wrap) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Commit FSM state register.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit FSM next state: a commit seen on a boundary cycle waits for the next boundary.
    always_comb begin
        state_d = state_q;
        copy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_edge) begin
                    state_d = ST_IDLE;
                    copy_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            // Per-digit shadow and active registers.
            always_ff @(posedge mclk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_q[gi] <= 4'h0;
                    active_q[gi] <= 4'h0;
                end else begin
                    if (wr_en && (bus.wr_addr == 2'(gi))) begin
                        shadow_q[gi] <= bus.wr_data;
                    end
                    if (copy_d) begin
                        active_q[gi] <= shadow_q[gi];
                    end
                end
            end
        end
    endgenerate

    // Anode pattern: the top three prescaler bits form the PWM phase for brightness.
    always_comb begin
        lit  = bus.digit_en[idx_q] && (prescale_q[PRESCALE_W-1 -: 3] <= bus.brightness);
        an_d = 4'hF;
        if (lit) begin
            an_d = ~(4'(1) << idx_q);
        end
    end

    // Output registers; frame_start is delayed one extra cycle to line up with digit 0 on an.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            value_q       <= 4'h0;
            an_q          <= 4'hF;
            commit_done_q <= 1'b0;
            frame_edge_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            value_q       <= active_q[idx_q];
            an_q          <= an_d;
            commit_done_q <= copy_d;
            frame_edge_q  <= frame_edge;
            frame_start_q <= frame_edge_q;
        end
    end

    assign bus.wr_ready    = (state_q == ST_IDLE);
    assign bus.commit_done = commit_done_q;
    assign bus.value       = value_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomised bench for sseg_scan_ctrl with a cycle-count based reference model.
module tb_sseg_scan_ctrl;

    localparam int PW  = 4;
    localparam int DW  = 1 << PW;      // dwell cycles per digit
    localparam int FRM = 4 * DW;       // cycles per frame

    logic mclk;
    logic reset_n;

    sseg_scan_ctrl_if ifc ();

    sseg_scan_ctrl #(.PRESCALE_W(PW)) dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_cmp;
    int n_bad;

    // Model state: edges since reset release, the two banks and the pending flag.
    int         n_edge;
    logic [3:0] m_shadow [4];
    logic [3:0] m_active [4];
    bit         m_pend;
    bit         m_prev_bnd;

    logic [3:0] e_an;
    logic [3:0] e_val;
    bit         e_done;
    bit         e_fs;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n_edge, got, exp);
        end
    endtask

    task automatic model_clear();
        n_edge     = 0;
        m_pend     = 0;
        m_prev_bnd = 0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 4'h0;
            m_active[i] = 4'h0;
        end
    endtask

    // One clock: model the edge from elapsed-cycle arithmetic, then compare at the falling edge.
    task automatic step();
        int         p;
        int         d;
        bit         bnd;
        bit         lit;
        logic [3:0] onehot;
        @(posedge mclk);
        n_edge++;
        p      = (n_edge - 1) % DW;
        d      = ((n_edge - 1) / DW) % 4;
        bnd    = (p == DW - 1) && (d == 3);
        lit    = ifc.digit_en[d] && ((p >> (PW - 3)) <= int'(ifc.brightness));
        onehot = 4'b0001 << d;
        e_an   = lit ? ~onehot : 4'hF;
        e_val  = m_active[d];
        e_fs   = m_prev_bnd;
        m_prev_bnd = bnd;
        e_done = 0;
        if (m_pend) begin
            if (bnd) begin
                for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
                m_pend = 0;
                e_done = 1;
                $display("edge %0d: commit -> active %h %h %h %h", n_edge,
                         m_active[3], m_active[2], m_active[1], m_active[0]);
            end
        end else begin
            if (ifc.wr_valid) m_shadow[ifc.wr_addr] = ifc.wr_data;
            if (ifc.commit)   m_pend = 1;
        end
        @(negedge mclk);
        check_val("an",          int'(ifc.an),          int'(e_an));
        check_val("value",       int'(ifc.value),       int'(e_val));
        check_val("commit_done", int'(ifc.commit_done), int'(e_done));
        check_val("frame_start", int'(ifc.frame_start), int'(e_fs));
        check_val("wr_ready",    int'(ifc.wr_ready),    int'(!m_pend));
    endtask

    // Asynchronous reset away from the rising edge; outputs must clear at once.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_an",          int'(ifc.an),          15);
        check_val("rst_value",       int'(ifc.value),       0);
        check_val("rst_wr_ready",    int'(ifc.wr_ready),    1);
        check_val("rst_commit_done", int'(ifc.commit_done), 0);
        check_val("rst_frame_start", int'(ifc.frame_start), 0);
        model_clear();
        @(negedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        #1;
        check_val("rel_an", int'(ifc.an), 15);
    endtask

    task automatic idle_inputs();
        ifc.wr_valid = 1'b0;
        ifc.wr_addr  = 2'd0;
        ifc.wr_data  = 4'h0;
        ifc.commit   = 1'b0;
    endtask

    int lat;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b1;
        idle_inputs();
        ifc.digit_en   = 4'hF;
        ifc.brightness = 3'd7;
        @(negedge mclk);
        do_reset();

        // Free-running scan with empty banks over two frames.
        repeat (2 * FRM + 4) step();

        // Fill shadow with A..D then commit; later writes while pending are refused.
        for (int i = 0; i < 4; i++) begin
            ifc.wr_valid = 1'b1;
            ifc.wr_addr  = 2'(i);
            ifc.wr_data  = 4'(10 + i);
            step();
        end
        idle_inputs();
        ifc.commit = 1'b1;
        step();
        ifc.commit   = 1'b0;
        ifc.wr_valid = 1'b1;
        ifc.wr_addr  = 2'd2;
        ifc.wr_data  = 4'h5;
        repeat (10) step();
        idle_inputs();
        repeat (FRM + 2 * DW) step();

        // Lowest duty, then digit 2 blanked.
        ifc.brightness = 3'd0;
        repeat (FRM) step();
        ifc.digit_en = 4'b1011;
        repeat (FRM) step();
        ifc.digit_en   = 4'hF;
        ifc.brightness = 3'd7;

        // Commit on a frame-boundary cycle: the copy waits a full frame.
        while ((n_edge % FRM) != FRM - 1) step();
        ifc.commit = 1'b1;
        step();
        ifc.commit = 1'b0;
        lat = 0;
        for (int i = 1; i <= FRM + 16; i++) begin
            step();
            if (ifc.commit_done) begin
                lat = i;
                break;
            end
        end
        check_val("boundary_commit_latency", lat, FRM);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            ifc.wr_valid = 1'($urandom_range(0, 1));
            ifc.wr_addr  = 2'($urandom_range(0, 3));
            ifc.wr_data  = 4'($urandom_range(0, 15));
            ifc.commit   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) ifc.digit_en   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) ifc.brightness = 3'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        ifc.digit_en   = 4'hF;
        ifc.brightness = 3'd7;

        // Reset while a commit is pending mid-frame; no commit_done afterwards.
        for (int i = 0; i < 4; i++) begin
            ifc.wr_valid = 1'b1;
            ifc.wr_addr  = 2'(i);
            ifc.wr_data  = 4'(3 + i);
            step();
        end
        idle_inputs();
        while (!ifc.wr_ready) step();
        ifc.commit = 1'b1;
        step();
        ifc.commit = 1'b0;
        repeat (20) step();
        check_val("pending_before_reset", int'(ifc.wr_ready), 0);
        do_reset();
        repeat (2 * FRM + 8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
